// File: rtl/muldiv_pkg.sv
// Shared op/state types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return (op inside {OP_REM, OP_REMU});
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shifted_s;
    logic           ge_s;

    // Multiply: hi:lo shifts right with the carry; divide: hi is the running remainder, lo collects quotient bits.
    always_comb begin
        sum_s     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        shifted_s = {hi, lo[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, opb});
        if (div_mode) begin
            lo_nxt = {lo[WIDTH-2:0], ge_s};
            if (ge_s) begin
                hi_nxt = shifted_s[WIDTH-1:0] - opb;
            end else begin
                hi_nxt = shifted_s[WIDTH-1:0];
            end
        end else begin
            hi_nxt = sum_s[WIDTH:1];
            lo_nxt = {sum_s[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/valid handshake.
// Define MULDIV_FAST_MUL_EN to complete multiplies in one edge with a combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       MulDivControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             busy,
    output logic             ResultValid,
    output logic [WIDTH-1:0] MulDivResult
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e    state_r;
    muldiv_op_e       op_r;
    logic [WIDTH-1:0] hi_r, lo_r, opb_r, result_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sa_r, sb_r, busy_r, valid_r;

    muldiv_op_e         op_in_s;
    logic               sa_s, sb_s, special_s;
    logic [WIDTH-1:0]   absa_s, absb_s, special_val_s, fix_s, hi_nxt_s, lo_nxt_s;
    logic [2*WIDTH-1:0] pneg_s, pfix_s;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] pa_s, pb_s, prod_s;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div(op_r)),
        .hi       (hi_r),
        .lo       (lo_r),
        .opb      (opb_r),
        .hi_nxt   (hi_nxt_s),
        .lo_nxt   (lo_nxt_s)
    );

    // Operand decode at accept: magnitudes, signs and the single-edge special results.
    always_comb begin
        op_in_s       = muldiv_op_e'(MulDivControl);
        sa_s          = is_signed_a(op_in_s) & SrcA[WIDTH-1];
        sb_s          = is_signed_b(op_in_s) & SrcB[WIDTH-1];
        absa_s        = sa_s ? (ZERO - SrcA) : SrcA;
        absb_s        = sb_s ? (ZERO - SrcB) : SrcB;
        special_s     = 1'b0;
        special_val_s = ZERO;
`ifdef MULDIV_FAST_MUL_EN
        pa_s   = {{WIDTH{is_signed_a(op_in_s) & SrcA[WIDTH-1]}}, SrcA};
        pb_s   = {{WIDTH{is_signed_b(op_in_s) & SrcB[WIDTH-1]}}, SrcB};
        prod_s = pa_s * pb_s;
`endif
        if (is_div(op_in_s)) begin
            if (SrcB == ZERO) begin
                special_s     = 1'b1;
                special_val_s = is_rem(op_in_s) ? SrcA : ONES;
            end else if (is_signed_b(op_in_s) && (SrcA == SMIN) && (SrcB == ONES)) begin
                special_s     = 1'b1;
                special_val_s = is_rem(op_in_s) ? ZERO : SMIN;
            end else begin
                special_s     = 1'b0;
                special_val_s = ZERO;
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            special_s     = 1'b1;
            special_val_s = (op_in_s == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
`else
            special_s     = 1'b0;
            special_val_s = ZERO;
`endif
        end
    end

    // Sign correction and result selection applied in FIX; unsigned ops carry clear sign flags.
    always_comb begin
        pneg_s = {(2*WIDTH){1'b0}} - {hi_r, lo_r};
        pfix_s = (sa_r ^ sb_r) ? pneg_s : {hi_r, lo_r};
        case (op_r)
            OP_MUL:                       fix_s = pfix_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_s = pfix_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_s = (sa_r ^ sb_r) ? (ZERO - lo_r) : lo_r;
            OP_REM, OP_REMU:              fix_s = sa_r ? (ZERO - hi_r) : hi_r;
            default:                      fix_s = ZERO;
        endcase
    end

    // Control FSM with counter, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            op_r     <= OP_MUL;
            hi_r     <= ZERO;
            lo_r     <= ZERO;
            opb_r    <= ZERO;
            result_r <= ZERO;
            cnt_r    <= {CNT_W{1'b0}};
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        op_r  <= op_in_s;
                        sa_r  <= sa_s;
                        sb_r  <= sb_s;
                        hi_r  <= ZERO;
                        lo_r  <= absa_s;
                        opb_r <= absb_s;
                        if (special_s) begin
                            state_r  <= DONE;
                            result_r <= special_val_s;
                            busy_r   <= 1'b0;
                            valid_r  <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            cnt_r   <= CNT_W'(WIDTH);
                            busy_r  <= 1'b1;
                            valid_r <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                CALC: begin
                    hi_r  <= hi_nxt_s;
                    lo_r  <= lo_nxt_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    result_r <= fix_s;
                    state_r  <= DONE;
                    busy_r   <= 1'b0;
                    valid_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign ResultValid  = valid_r;
    assign MulDivResult = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MulDivControl = 3'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        ResultValid;
    logic [31:0] MulDivResult;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] last_exp = 32'd0;

    localparam logic [31:0] SMIN = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .MulDivControl (MulDivControl),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .flush         (flush),
        .busy          (busy),
        .ResultValid   (ResultValid),
        .MulDivResult  (MulDivResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] u;
        longint      p;
        int          sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 32'd0) return ONES;
                if (a == SMIN && b == ONES) return SMIN;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? ONES : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == SMIN && b == ONES) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'd0 || (!op[0] && a == SMIN && b == ONES)) return 1;
            return 34;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 34;
`endif
    endfunction

    // b2b: caller already sits in a DONE cycle; poke_at/flush_at: cycle index after accept (0 = unused)
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit b2b, input int poke_at, input int flush_at);
        int          n, busy_n, vcnt, lat;
        logic [31:0] exp;
        exp = model(op, a, b);
        lat = exp_lat(op, a, b);
        if (!b2b) @(negedge clk);
        start = 1'b1; MulDivControl = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        start = 1'b0;
        MulDivControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        n = 1; busy_n = 0; vcnt = 0;
        if (flush_at > 0) begin
            while (n < 45) begin
                flush = (n == flush_at);
                if (ResultValid) vcnt++;
                @(posedge clk); #1;
                n++;
            end
            flush = 1'b0;
            check("flush_no_valid", 32'(vcnt), 32'd0);
            check("flush_result_hold", MulDivResult, last_exp);
            check("flush_busy", {31'd0, busy}, 32'd0);
        end else begin
            while (!ResultValid && n < 100) begin
                if (busy) busy_n++;
                start = (n == poke_at);
                @(posedge clk); #1;
                n++;
            end
            start = 1'b0;
            check("latency", 32'(n), 32'(lat));
            check("result", MulDivResult, exp);
            check("busy_cycles", 32'(busy_n), 32'(lat - 1));
            check("busy_at_valid", {31'd0, busy}, 32'd0);
            last_exp = exp;
            if (poke_at > 0) begin
                repeat (40) begin
                    @(posedge clk); #1;
                    if (ResultValid) vcnt++;
                end
                check("poke_no_extra_valid", 32'(vcnt), 32'd0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, ResultValid}, 32'd0);
        check("reset_result", MulDivResult, 32'd0);
        @(negedge clk); rst = 1'b0;

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run(3'd1, SMIN, SMIN, 1'b0, 0, 0);
        run(3'd3, ONES, ONES, 1'b0, 0, 0);
        run(3'd2, ONES, 32'd2, 1'b0, 0, 0);
        run(3'd5, 32'd100, 32'd7, 1'b0, 0, 0);
        run(3'd7, 32'd100, 32'd7, 1'b0, 0, 0);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
        run(3'd4, 32'd5, 32'd0, 1'b0, 0, 0);
        run(3'd6, 32'd5, 32'd0, 1'b0, 0, 0);
        run(3'd4, SMIN, ONES, 1'b0, 0, 0);
        run(3'd6, SMIN, ONES, 1'b0, 0, 0);
        run(3'd5, 32'd1000, 32'd33, 1'b0, 10, 0);
        run(3'd4, 32'd77, 32'd5, 1'b1, 0, 0);
        run(3'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, 0, 0);
        run(3'd3, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 0, 5);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       begin a = SMIN; b = ONES; end
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run(op, a, b, 1'b0, 0, 0);
        end

        @(negedge clk);
        start = 1'b1; MulDivControl = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_valid", {31'd0, ResultValid}, 32'd0);
        check("rst_mid_result", MulDivResult, 32'd0);
        @(negedge clk); rst = 1'b0;
        last_exp = 32'd0;
        run(3'd5, 32'd9, 32'd3, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
